// File: rtl/seq_monitor_pkg.sv
// Shared definitions for the seq_monitor block: sample widths, limits and FSM encoding.
package seq_monitor_pkg;
   localparam int                CNT_W     = 5;
   localparam logic [CNT_W-1:0]  CNT_MAX   = 5'd31;
   localparam int                ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_LOCKING  = 2'b01,
      ST_LOCKED   = 2'b10
   } state_t;
endpackage

// File: rtl/seq_pred.sv
// Combinational next-value predictor for the upstream skip counter.
import seq_monitor_pkg::*;

module seq_pred (
   input  logic [CNT_W-1:0] p,
   output logic [CNT_W-1:0] pred
);

   // 31 wraps to 0, 3..30 skip by two (mod 32), 0..2 step by one
   always_comb begin
      pred = p + 5'd1;
      if (p == CNT_MAX) begin
         pred = 5'd0;
      end else if (p > 5'd2) begin
         pred = p + 5'd2;
      end else begin
         pred = p + 5'd1;
      end
   end

endmodule

// File: rtl/seq_monitor.sv
// Lock/error monitor for the skip-counter sequence; all outputs registered.
// Define SEQ_MONITOR_ERR_CNT_EN to build the saturating err_cnt counter (else err_cnt is tied to 0).
import seq_monitor_pkg::*;

module seq_monitor #(
   parameter int LOCK_N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNT_W-1:0]     cnt_in,
   input  logic                 cnt_vld,
   input  logic                 clr,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 wrap_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

   state_t           state_r;
   logic [CNT_W-1:0] hist_r;
   logic             hist_vld_r;
   logic [3:0]       run_r;
   logic             locked_r;
   logic             err_pulse_r;
   logic             wrap_pulse_r;
   logic [CNT_W-1:0] pred_s;
   logic             match_s;
   logic [3:0]       run_inc_s;
   logic             wrap_s;

   seq_pred u_pred (
      .p    (hist_r),
      .pred (pred_s)
   );

   assign match_s   = (cnt_in == pred_s);
   assign run_inc_s = (run_r >= LOCK_N_C) ? LOCK_N_C : (run_r + 4'd1);
   assign wrap_s    = (hist_r == CNT_MAX) && (cnt_in == 5'd0);

   // Sequence FSM: history, match run and the registered lock/pulse outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_UNLOCKED;
         hist_r       <= 5'd0;
         hist_vld_r   <= 1'b0;
         run_r        <= 4'd0;
         locked_r     <= 1'b0;
         err_pulse_r  <= 1'b0;
         wrap_pulse_r <= 1'b0;
      end else if (clr) begin
         state_r      <= ST_UNLOCKED;
         hist_r       <= 5'd0;
         hist_vld_r   <= 1'b0;
         run_r        <= 4'd0;
         locked_r     <= 1'b0;
         err_pulse_r  <= 1'b0;
         wrap_pulse_r <= 1'b0;
      end else begin
         err_pulse_r  <= 1'b0;
         wrap_pulse_r <= 1'b0;
         if (cnt_vld) begin
            hist_r     <= cnt_in;
            hist_vld_r <= 1'b1;
            // The very first sample after reset/clear only seeds the history
            if (hist_vld_r) begin
               case (state_r)
                  ST_UNLOCKED, ST_LOCKING: begin
                     if (match_s) begin
                        run_r <= run_inc_s;
                        if (run_inc_s >= LOCK_N_C) begin
                           state_r  <= ST_LOCKED;
                           locked_r <= 1'b1;
                        end else begin
                           state_r  <= ST_LOCKING;
                           locked_r <= 1'b0;
                        end
                     end else begin
                        run_r    <= 4'd0;
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                     end
                  end
                  ST_LOCKED: begin
                     if (match_s) begin
                        run_r        <= run_inc_s;
                        wrap_pulse_r <= wrap_s;
                     end else begin
                        run_r       <= 4'd0;
                        state_r     <= ST_UNLOCKED;
                        locked_r    <= 1'b0;
                        err_pulse_r <= 1'b1;
                     end
                  end
                  default: begin
                     run_r    <= 4'd0;
                     state_r  <= ST_UNLOCKED;
                     locked_r <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign locked     = locked_r;
   assign err_pulse  = err_pulse_r;
   assign wrap_pulse = wrap_pulse_r;

`ifdef SEQ_MONITOR_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_r;
   logic                 err_event_s;

   assign err_event_s = cnt_vld && hist_vld_r && (state_r == ST_LOCKED) && !match_s;

   // Saturating count of sequence breaks seen while locked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (clr) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (err_event_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed scenarios plus random traffic against a reference model.
module tb_seq_monitor;

   localparam int LOCK_N = 4;

   logic       clk;
   logic       rst;
   logic [4:0] cnt_in;
   logic       cnt_vld;
   logic       clr;
   logic       locked;
   logic       err_pulse;
   logic       wrap_pulse;
   logic [7:0] err_cnt;

   int n_cmp;
   int n_bad;

   // Reference model: history value, consecutive-match run, lock flag, error total
   int m_hist;
   bit m_hvld;
   int m_run;
   bit m_lock;
   int m_err;
   bit m_ep;
   bit m_wp;

   seq_monitor #(.LOCK_N(LOCK_N)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .cnt_vld    (cnt_vld),
      .clr        (clr),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .wrap_pulse (wrap_pulse),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pred_f(input int p);
      if (p == 31) return 0;
      if (p > 2 && p < 31) return (p + 2) % 32;
      return p + 1;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist = 0; m_hvld = 0; m_run = 0; m_lock = 0; m_err = 0; m_ep = 0; m_wp = 0;
   endtask

   task automatic model_step(input bit v, input int d, input bit c);
      m_ep = 0;
      m_wp = 0;
      if (c) begin
         model_reset();
      end else if (v) begin
         if (m_hvld) begin
            if (d == pred_f(m_hist)) begin
               if (m_lock && m_hist == 31 && d == 0) m_wp = 1;
               m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
               if (m_run == LOCK_N) m_lock = 1;
            end else begin
               if (m_lock) begin
                  m_ep = 1;
                  if (m_err < 255) m_err++;
               end
               m_lock = 0;
               m_run  = 0;
            end
         end
         m_hist = d;
         m_hvld = 1;
      end
   endtask

   function automatic int exp_err_cnt();
`ifdef SEQ_MONITOR_ERR_CNT_EN
      return m_err;
`else
      return 0;
`endif
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".locked"}, int'(locked), int'(m_lock));
      check({tag, ".err_pulse"}, int'(err_pulse), int'(m_ep));
      check({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(m_wp));
      check({tag, ".err_cnt"}, int'(err_cnt), exp_err_cnt());
   endtask

   // One clock: drive on the falling edge, model on the rising edge, sample 1 ns later
   task automatic step(input string tag, input bit v, input int d, input bit c);
      @(negedge clk);
      cnt_vld = v;
      cnt_in  = 5'(d);
      clr     = c;
      @(posedge clk);
      model_step(v, d, c);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cnt_vld = 1'b0; clr = 1'b0; cnt_in = 5'd0;
      #1;
      model_reset();
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int p;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; cnt_vld = 1'b0; clr = 1'b0; cnt_in = 5'd0;
      model_reset();
      #12;
      check_outputs("por");
      @(negedge clk);
      rst = 1'b0;

      // Lock acquisition: 0 seeds, 1,2,3,5 are four matches
      step("lock", 1'b1, 0, 1'b0);
      step("lock", 1'b1, 1, 1'b0);
      step("lock", 1'b1, 2, 1'b0);
      step("lock", 1'b1, 3, 1'b0);
      check("pre_lock", int'(locked), 0);
      step("lock", 1'b1, 5, 1'b0);
      check("lock_on_5", int'(locked), 1);
      check("lock_err0", int'(err_cnt), 0);

      // Walk the skip sequence up to 29, then 31 -> 0 wrap
      p = 5;
      while (p != 29) begin
         p = pred_f(p);
         step("walk", 1'b1, p, 1'b0);
      end
      step("wrap", 1'b1, 31, 1'b0);
      check("no_wrap_at_31", int'(wrap_pulse), 0);
      step("wrap", 1'b1, 0, 1'b0);
      check("wrap_at_0", int'(wrap_pulse), 1);
      step("wrap", 1'b0, 0, 1'b0);
      check("wrap_one_cycle", int'(wrap_pulse), 0);

      // Break while locked: 1,2,3,5,7 then 10; afterwards 10,12 must not pulse
      step("brk", 1'b1, 1, 1'b0);
      step("brk", 1'b1, 2, 1'b0);
      step("brk", 1'b1, 3, 1'b0);
      step("brk", 1'b1, 5, 1'b0);
      step("brk", 1'b1, 7, 1'b0);
      step("brk", 1'b1, 10, 1'b0);
      check("brk_pulse", int'(err_pulse), 1);
      check("brk_unlock", int'(locked), 0);
      step("brk", 1'b1, 10, 1'b0);
      check("brk_no_pulse_a", int'(err_pulse), 0);
      step("brk", 1'b1, 12, 1'b0);
      check("brk_no_pulse_b", int'(err_pulse), 0);

      // clr together with a sample: sample dropped, history invalidated
      step("clr", 1'b1, 1, 1'b0);
      step("clr", 1'b1, 2, 1'b1);
      check("clr_err0", int'(err_cnt), 0);
      step("clr", 1'b1, 9, 1'b0);
      step("clr", 1'b1, 11, 1'b0);
      step("clr", 1'b1, 13, 1'b0);
      step("clr", 1'b1, 15, 1'b0);
      check("clr_not_yet", int'(locked), 0);
      step("clr", 1'b1, 17, 1'b0);
      check("clr_relock", int'(locked), 1);

      // Idle gap of 10 cycles between 3 and 5 keeps history and run
      do_reset();
      step("gap", 1'b1, 2, 1'b0);
      step("gap", 1'b1, 3, 1'b0);
      for (int i = 0; i < 10; i++) step("gap_idle", 1'b0, $urandom_range(0, 31), 1'b0);
      step("gap", 1'b1, 5, 1'b0);
      step("gap", 1'b1, 7, 1'b0);
      step("gap", 1'b1, 9, 1'b0);
      check("gap_lock", int'(locked), 1);

      // Asynchronous reset mid-run drops lock at once, no pulses after release
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_lock", int'(locked), 0);
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 1'b0, 0, 1'b0);
      step("post_rst", 1'b1, 20, 1'b0);

      // Random traffic biased toward correct sequences
      for (int i = 0; i < 600; i++) begin
         bit v, c;
         int d;
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 63) == 0);
         if (m_hvld && $urandom_range(0, 9) < 8) d = pred_f(m_hist);
         else d = $urandom_range(0, 31);
         step("rand", v, d, c);
      end

      // 260 lock/break cycles to drive err_cnt into saturation
      do_reset();
      step("sat", 1'b1, 0, 1'b0);
      for (int k = 0; k < 260; k++) begin
         for (int j = 0; j < LOCK_N; j++) step("sat", 1'b1, pred_f(m_hist), 1'b0);
         step("sat_brk", 1'b1, pred_f(m_hist) ^ 1, 1'b0);
         check("sat_pulse", int'(err_pulse), 1);
      end
`ifdef SEQ_MONITOR_ERR_CNT_EN
      check("sat_value", int'(err_cnt), 255);
`else
      check("sat_value", int'(err_cnt), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
